// File: rtl/sdram_arb_pkg.sv
// Shared types and constants for the SDRAM port arbiter.
//   arb_state_t : arbiter FSM states (IDLE, RD, WR, GAP)
//   BE_ALL      : byte-enable pattern driven with every bridge command
//   DEF_*       : default parameter values for the arbiter top
package sdram_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        GAP  = 2'd3
    } arb_state_t;

    localparam logic [7:0] BE_ALL = 8'hFF;

    localparam int DEF_ADDR_W     = 23;
    localparam int DEF_DATA_W     = 64;
    localparam int DEF_TIMEOUT    = 1023;
    localparam int DEF_STARVE_MAX = 4;

endpackage

// File: rtl/arb_timeout_ctr.sv
// Bridge-transaction watchdog for the SDRAM port arbiter.
//   clk, reset_n : clock, asynchronous active-low reset
//   clr_i        : force the count to zero (held while no command is active)
//   en_i         : a command is waiting for br_ac this cycle
//   expired_o    : high in the TIMEOUT-th waiting cycle of a command
// With the counter cleared before the command starts, the strobe stays
// high for exactly TIMEOUT cycles before the arbiter aborts it.
module arb_timeout_ctr #(
    parameter int TIMEOUT = 1023
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign expired_o = en_i && (cnt_q == CW'(TIMEOUT - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && !expired_o) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/sdram_port_arbiter.sv
// Two-client arbiter (SD loader writes, audio reads) in front of the single
// 64-bit SDRAM bridge port. One transaction outstanding at a time, audio has
// priority, the loader is guaranteed a grant after STARVE_MAX audio grants.
//   Loader : init_we/init_addr/init_wrdata in, init_ac pulse out
//   Audio  : aud_rd/aud_addr in, aud_rddata/aud_ac/aud_wait out
//   Bridge : br_addr/br_be/br_read/br_write/br_wrdata out, br_ac/br_rddata in
//   Status : timeout_err (sticky), dbg_state_o (current FSM state)
// Handshake: client requests are levels held until their ac pulse and must
// drop on the edge where ac is seen; br_read/br_write are held stable until
// a one-cycle br_ac, and the GAP state guarantees the bridge sees each strobe
// deassert before the next command.
module sdram_port_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int TIMEOUT    = DEF_TIMEOUT,
    parameter int STARVE_MAX = DEF_STARVE_MAX
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              init_we,
    input  logic [ADDR_W-1:0] init_addr,
    input  logic [DATA_W-1:0] init_wrdata,
    output logic              init_ac,
    input  logic              aud_rd,
    input  logic [ADDR_W-1:0] aud_addr,
    output logic [DATA_W-1:0] aud_rddata,
    output logic              aud_ac,
    output logic              aud_wait,
    output logic [ADDR_W-1:0] br_addr,
    output logic [7:0]        br_be,
    output logic              br_read,
    output logic              br_write,
    output logic [DATA_W-1:0] br_wrdata,
    input  logic              br_ac,
    input  logic [DATA_W-1:0] br_rddata,
    output logic              timeout_err,
    output arb_state_t        dbg_state_o
);

    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

    arb_state_t        state_q,       state_d;
    logic [ADDR_W-1:0] br_addr_q,     br_addr_d;
    logic [DATA_W-1:0] br_wrdata_q,   br_wrdata_d;
    logic [7:0]        br_be_q,       br_be_d;
    logic              br_read_q,     br_read_d;
    logic              br_write_q,    br_write_d;
    logic [DATA_W-1:0] aud_rddata_q,  aud_rddata_d;
    logic              aud_ac_q,      aud_ac_d;
    logic              init_ac_q,     init_ac_d;
    logic [SW-1:0]     starve_q,      starve_d;
    logic              timeout_err_q, timeout_err_d;

    logic grant_aud;
    logic grant_init;
    logic busy;
    logic expired;

    // Audio wins unless the loader has already waited through STARVE_MAX
    // audio grants.
    assign grant_aud  = aud_rd && (!init_we || (starve_q < STARVE_LIM));
    assign grant_init = !grant_aud && init_we;
    assign busy       = (state_q == RD) || (state_q == WR);

    arb_timeout_ctr #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk       (clk),
        .reset_n   (reset_n),
        .clr_i     (!busy),
        .en_i      (busy && !br_ac),
        .expired_o (expired)
    );

    always_comb begin
        state_d       = state_q;
        br_addr_d     = br_addr_q;
        br_wrdata_d   = br_wrdata_q;
        br_be_d       = br_be_q;
        br_read_d     = br_read_q;
        br_write_d    = br_write_q;
        aud_rddata_d  = aud_rddata_q;
        aud_ac_d      = 1'b0;
        init_ac_d     = 1'b0;
        starve_d      = starve_q;
        timeout_err_d = timeout_err_q;

        case (state_q)
            IDLE: begin
                if (grant_aud) begin
                    br_addr_d = aud_addr;
                    br_read_d = 1'b1;
                    br_be_d   = BE_ALL;
                    state_d   = RD;
                    if (init_we) begin
                        if (starve_q != STARVE_LIM) begin
                            starve_d = starve_q + SW'(1);
                        end
                    end else begin
                        starve_d = '0;
                    end
                end else if (grant_init) begin
                    br_addr_d   = init_addr;
                    br_wrdata_d = init_wrdata;
                    br_write_d  = 1'b1;
                    br_be_d     = BE_ALL;
                    state_d     = WR;
                    starve_d    = '0;
                end else begin
                    starve_d = '0;
                end
            end
            RD: begin
                if (br_ac || expired) begin
                    br_read_d    = 1'b0;
                    br_be_d      = '0;
                    aud_ac_d     = 1'b1;
                    // An aborted read returns zeros rather than stale data.
                    aud_rddata_d = br_ac ? br_rddata : '0;
                    if (!br_ac) begin
                        timeout_err_d = 1'b1;
                    end
                    state_d = GAP;
                end
            end
            WR: begin
                if (br_ac || expired) begin
                    br_write_d = 1'b0;
                    br_be_d    = '0;
                    init_ac_d  = 1'b1;
                    if (!br_ac) begin
                        timeout_err_d = 1'b1;
                    end
                    state_d = GAP;
                end
            end
            GAP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            br_addr_q     <= '0;
            br_wrdata_q   <= '0;
            br_be_q       <= '0;
            br_read_q     <= 1'b0;
            br_write_q    <= 1'b0;
            aud_rddata_q  <= '0;
            aud_ac_q      <= 1'b0;
            init_ac_q     <= 1'b0;
            starve_q      <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            br_addr_q     <= br_addr_d;
            br_wrdata_q   <= br_wrdata_d;
            br_be_q       <= br_be_d;
            br_read_q     <= br_read_d;
            br_write_q    <= br_write_d;
            aud_rddata_q  <= aud_rddata_d;
            aud_ac_q      <= aud_ac_d;
            init_ac_q     <= init_ac_d;
            starve_q      <= starve_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign br_addr     = br_addr_q;
    assign br_wrdata   = br_wrdata_q;
    assign br_be       = br_be_q;
    assign br_read     = br_read_q;
    assign br_write    = br_write_q;
    assign aud_rddata  = aud_rddata_q;
    assign aud_ac      = aud_ac_q;
    assign init_ac     = init_ac_q;
    assign aud_wait    = aud_rd & ~aud_ac_q;
    assign timeout_err = timeout_err_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Directed bench for sdram_port_arbiter: single read, stray ack, single
// write, audio/loader contention, timeout, reset during a read.
module tb_sdram_port_arbiter;
  import sdram_arb_pkg::*;

  localparam int ADDR_W = 23;
  localparam int DATA_W = 64;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n;
  always #10 clk = ~clk;

  logic              init_we;
  logic [ADDR_W-1:0] init_addr;
  logic [DATA_W-1:0] init_wrdata;
  logic              init_ac;
  logic              aud_rd;
  logic [ADDR_W-1:0] aud_addr;
  logic [DATA_W-1:0] aud_rddata;
  logic              aud_ac;
  logic              aud_wait;
  logic [ADDR_W-1:0] br_addr;
  logic [7:0]        br_be;
  logic              br_read;
  logic              br_write;
  logic [DATA_W-1:0] br_wrdata;
  logic              br_ac;
  logic [DATA_W-1:0] br_rddata;
  logic              timeout_err;
  arb_state_t        dbg_state;

  sdram_port_arbiter #(
    .ADDR_W     (ADDR_W),
    .DATA_W     (DATA_W),
    .TIMEOUT    (16),
    .STARVE_MAX (4)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .init_we     (init_we),
    .init_addr   (init_addr),
    .init_wrdata (init_wrdata),
    .init_ac     (init_ac),
    .aud_rd      (aud_rd),
    .aud_addr    (aud_addr),
    .aud_rddata  (aud_rddata),
    .aud_ac      (aud_ac),
    .aud_wait    (aud_wait),
    .br_addr     (br_addr),
    .br_be       (br_be),
    .br_read     (br_read),
    .br_write    (br_write),
    .br_wrdata   (br_wrdata),
    .br_ac       (br_ac),
    .br_rddata   (br_rddata),
    .timeout_err (timeout_err),
    .dbg_state_o (dbg_state)
  );

  // ---------------- counters / scoreboard ----------------
  int pass_cnt = 0;
  int fail_cnt = 0;
  int total_cnt = 0;
  logic [DATA_W-1:0] exp_q[$];
  logic [7:0] grant_log[$];
  bit log_en = 1'b0;
  int aud_ac_seen = 0;
  int init_ac_seen = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total_cnt++;
    assert (obs === exp) begin
      pass_cnt++;
    end else begin
      fail_cnt++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Returns at the negedge of the first cycle a strobe is visible.
  task automatic wait_cmd(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (br_read || br_write) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  // ---------------- monitor ----------------
  int low_run = 2;
  bit prev_strobe = 1'b0;
  always @(negedge clk) begin
    logic [DATA_W-1:0] e;
    check("one_strobe", 64'(br_read & br_write), 64'd0);
    if (br_read || br_write) begin
      if (!prev_strobe) begin
        check("gap_before_cmd", 64'(low_run >= 2), 64'd1);
        if (log_en) grant_log.push_back(br_read ? 8'h41 : 8'h49);
      end
      low_run = 0;
    end else begin
      low_run++;
    end
    prev_strobe = br_read || br_write;
    if (reset_n && aud_ac) begin
      aud_ac_seen++;
      if (exp_q.size() == 0) begin
        check("sb_underflow", 64'd1, 64'd0);
      end else begin
        e = exp_q.pop_front();
        check("sb_aud_rddata", 64'(aud_rddata), 64'(e));
      end
    end
    if (reset_n && init_ac) init_ac_seen++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  // ---------------- directed steps ----------------
  initial begin
    bit ok;
    bit is_rd;
    bit seen;
    int hi;
    int ac_snap;
    logic [DATA_W-1:0] d;
    logic [7:0] exp_order[10];
    exp_order = '{8'h41, 8'h41, 8'h41, 8'h41, 8'h49, 8'h41, 8'h41, 8'h41, 8'h41, 8'h49};

    reset_n = 1'b0; init_we = 1'b0; init_addr = '0; init_wrdata = '0;
    aud_rd = 1'b0; aud_addr = '0; br_ac = 1'b0; br_rddata = '0;

    // reset values
    repeat (2) @(negedge clk);
    check("rst_br_read", 64'(br_read), 64'd0);
    check("rst_br_write", 64'(br_write), 64'd0);
    check("rst_br_be", 64'(br_be), 64'd0);
    check("rst_br_addr", 64'(br_addr), 64'd0);
    check("rst_br_wrdata", 64'(br_wrdata), 64'd0);
    check("rst_aud_ac", 64'(aud_ac), 64'd0);
    check("rst_init_ac", 64'(init_ac), 64'd0);
    check("rst_aud_rddata", 64'(aud_rddata), 64'd0);
    check("rst_timeout_err", 64'(timeout_err), 64'd0);
    check("rst_state", 64'(dbg_state), 64'(IDLE));
    reset_n = 1'b1;
    tick();

    // single audio read, bridge acks in the 6th command cycle
    aud_addr = 23'h000100; aud_rd = 1'b1;
    @(negedge clk);
    check("rd_c0_no_strobe", 64'(br_read), 64'd0);
    check("rd_c0_aud_wait", 64'(aud_wait), 64'd1);
    for (int c = 1; c <= 6; c++) begin
      tick();
      if (c == 6) begin
        br_ac = 1'b1; br_rddata = 64'hDEADBEEF_01234567;
        exp_q.push_back(64'hDEADBEEF_01234567);
      end
      @(negedge clk);
      check("rd_strobe", 64'(br_read), 64'd1);
      check("rd_aud_wait", 64'(aud_wait), 64'd1);
      if (c == 1) begin
        check("rd_addr", 64'(br_addr), 64'h000100);
        check("rd_be", 64'(br_be), 64'hFF);
        check("rd_no_write", 64'(br_write), 64'd0);
      end
    end
    tick(); br_ac = 1'b0; br_rddata = '0;
    @(negedge clk);
    check("rd_ac", 64'(aud_ac), 64'd1);
    check("rd_data", 64'(aud_rddata), 64'hDEADBEEF_01234567);
    check("rd_strobe_dropped", 64'(br_read), 64'd0);
    check("rd_be_dropped", 64'(br_be), 64'd0);
    check("rd_wait_low", 64'(aud_wait), 64'd0);
    check("rd_gap_state", 64'(dbg_state), 64'(GAP));
    tick(); aud_rd = 1'b0;
    @(negedge clk);
    check("rd_ac_one_cycle", 64'(aud_ac), 64'd0);
    check("rd_idle_state", 64'(dbg_state), 64'(IDLE));

    // stray ack while idle
    tick(); br_ac = 1'b1; br_rddata = 64'h0BAD_0BAD_0BAD_0BAD;
    tick(); br_ac = 1'b0; br_rddata = '0;
    @(negedge clk);
    check("stray_aud_ac", 64'(aud_ac), 64'd0);
    check("stray_init_ac", 64'(init_ac), 64'd0);
    check("stray_rddata", 64'(aud_rddata), 64'hDEADBEEF_01234567);
    check("stray_state", 64'(dbg_state), 64'(IDLE));

    // single loader write
    tick();
    init_addr = 23'h7FFFFF; init_wrdata = 64'h11223344_55667788; init_we = 1'b1;
    wait_cmd(ok);
    check("wr_cmd_seen", 64'(ok), 64'd1);
    check("wr_strobe", 64'(br_write), 64'd1);
    check("wr_no_read", 64'(br_read), 64'd0);
    check("wr_addr", 64'(br_addr), 64'h7FFFFF);
    check("wr_data", 64'(br_wrdata), 64'h11223344_55667788);
    check("wr_be", 64'(br_be), 64'hFF);
    tick(); br_ac = 1'b1;
    tick(); br_ac = 1'b0;
    @(negedge clk);
    check("wr_ac", 64'(init_ac), 64'd1);
    check("wr_gap_write", 64'(br_write), 64'd0);
    check("wr_gap_read", 64'(br_read), 64'd0);
    check("wr_gap_state", 64'(dbg_state), 64'(GAP));
    tick(); init_we = 1'b0;
    @(negedge clk);
    check("wr_ac_one_cycle", 64'(init_ac), 64'd0);

    // contention: both requests held, 2-cycle bridge ack
    tick();
    aud_addr = 23'h012345; init_addr = 23'h054321; init_wrdata = 64'hA5A5_5A5A_0F0F_F0F0;
    aud_rd = 1'b1; init_we = 1'b1; log_en = 1'b1;
    for (int k = 0; k < 10; k++) begin
      wait_cmd(ok);
      check("cont_cmd_seen", 64'(ok), 64'd1);
      is_rd = br_read;
      d = {$urandom, $urandom_range(32'hFFFF_FFFF, 1)};
      tick();
      br_ac = 1'b1; br_rddata = d;
      if (is_rd) exp_q.push_back(d);
      tick();
      br_ac = 1'b0; br_rddata = '0;
      if (k == 9) begin
        aud_rd = 1'b0; init_we = 1'b0;
      end
    end
    log_en = 1'b0;
    check("cont_grants", 64'(grant_log.size()), 64'd10);
    for (int k = 0; k < 10; k++) begin
      if (k < grant_log.size()) check("cont_order", 64'(grant_log[k]), 64'(exp_order[k]));
    end

    // timeout: bridge never acks
    tick();
    aud_addr = 23'h0ABCDE; aud_rd = 1'b1; exp_q.push_back('0);
    hi = 0; seen = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (br_read) hi++;
      if (aud_ac) begin
        seen = 1'b1;
        break;
      end
      tick();
    end
    check("to_ac_seen", 64'(seen), 64'd1);
    check("to_strobe_cycles", 64'(hi), 64'd16);
    check("to_rddata_zero", 64'(aud_rddata), 64'd0);
    check("to_err_set", 64'(timeout_err), 64'd1);
    check("to_strobe_dropped", 64'(br_read), 64'd0);
    tick(); aud_rd = 1'b0;

    // write after timeout completes normally, error stays sticky
    tick();
    init_addr = 23'h000007; init_wrdata = 64'hCAFEF00D_12345678; init_we = 1'b1;
    wait_cmd(ok);
    check("to_wr_cmd_seen", 64'(ok), 64'd1);
    check("to_wr_data", 64'(br_wrdata), 64'hCAFEF00D_12345678);
    tick(); br_ac = 1'b1;
    tick(); br_ac = 1'b0;
    @(negedge clk);
    check("to_wr_ac", 64'(init_ac), 64'd1);
    check("to_err_sticky", 64'(timeout_err), 64'd1);
    tick(); init_we = 1'b0;

    // reset asserted while a read is outstanding
    tick();
    aud_addr = 23'h055555; aud_rd = 1'b1;
    wait_cmd(ok);
    check("rst_rd_cmd_seen", 64'(ok), 64'd1);
    tick();
    #4 reset_n = 1'b0;
    #1;
    check("rstm_br_read", 64'(br_read), 64'd0);
    check("rstm_br_be", 64'(br_be), 64'd0);
    check("rstm_br_addr", 64'(br_addr), 64'd0);
    check("rstm_aud_ac", 64'(aud_ac), 64'd0);
    check("rstm_aud_rddata", 64'(aud_rddata), 64'd0);
    check("rstm_timeout_err", 64'(timeout_err), 64'd0);
    check("rstm_state", 64'(dbg_state), 64'(IDLE));
    ac_snap = aud_ac_seen;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    wait_cmd(ok);
    check("rstm_no_ac", 64'(aud_ac_seen), 64'(ac_snap));
    check("rstm_fresh_read", 64'(ok && br_read), 64'd1);
    check("rstm_fresh_addr", 64'(br_addr), 64'h055555);
    tick(); br_ac = 1'b1; br_rddata = 64'h0123_4567_89AB_CDEF;
    exp_q.push_back(64'h0123_4567_89AB_CDEF);
    tick(); br_ac = 1'b0; br_rddata = '0;
    @(negedge clk);
    check("rstm_fresh_ac", 64'(aud_ac), 64'd1);
    tick(); aud_rd = 1'b0;

    // final report
    repeat (3) tick();
    @(negedge clk);
    check("sb_empty", 64'(exp_q.size()), 64'd0);
    check("aud_ac_total", 64'(aud_ac_seen), 64'd11);
    check("init_ac_total", 64'(init_ac_seen), 64'd4);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
